axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter ADDR_W, 32, AXI address width.
REQ-002 Parameter DATA_W, 32, AXI data width; fixed at 32.
REQ-003 ACLK  in  1  clock; reset ARESETn, synchronous, active-low; clock ACLK.
REQ-004 ARESETn  in  1  synchronous active-low reset.
REQ-005 cmd_valid  in  1  user command present.
REQ-006 cmd_ready  out  1  block accepts command.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  32  target address.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 cmd_wstrb  in  4  write byte strobes.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  user accepts response.
REQ-013 rsp_rdata  out  32  read data (0 for writes).
REQ-014 rsp_resp  out  2  BRESP or RRESP of completed transaction.
REQ-015 rsp_write  out  1  response belongs to write.
REQ-016 AWADDR/AWVALID/AWREADY(in)/AWPROT(3)/WDATA/WSTRB/WVALID/WREADY(in)/BVALID(in)/BREADY/BRESP(in,2) -- AXI4-Lite write channels, master side.
REQ-017 ARADDR/ARVALID/ARREADY(in)/ARPROT(3)/RVALID(in)/RREADY/RDATA(in,32)/RRESP(in,2) -- AXI4-Lite read channels, master side.
REQ-018 wr_count, rd_count  out  16 each  completed write/read counts; err_count  out  8  non-OKAY responses.

Function
REQ-019 States: IDLE, WREQ, WRESP, RREQ, RDATA, RSP; one transaction outstanding at a time.
REQ-020 cmd_ready = 1 only in IDLE; cmd_valid&cmd_ready latches cmd_addr/wdata/wstrb/write into registers and moves to WREQ (write) or RREQ (read) next cycle.
REQ-021 AXI outputs driven only from latched registers; later cmd_* changes have no effect on an active transaction.
REQ-022 WREQ: AWVALID and WVALID asserted together on entry; each deasserts the cycle after its own handshake (VALID&READY); aw_done/w_done flags tracked independently; exit to WRESP when both done (same-cycle handshakes allowed).
REQ-023 AWVALID/WVALID/ARVALID, once asserted, SHALL NOT drop before handshake; address/data stable while VALID.
REQ-024 WRESP: BREADY=1; on BVALID capture BRESP, go to RSP.
REQ-025 RREQ: ARVALID=1 until ARREADY; then RDATA state with RREADY=1; on RVALID capture RDATA and RRESP, go to RSP.
REQ-026 BREADY/RREADY SHALL be 0 outside WRESP/RDATA.
REQ-027 RSP: rsp_valid=1, rsp_* stable until rsp_ready; then IDLE. Minimum command-to-command spacing = 1 IDLE cycle.
REQ-028 AWPROT=ARPROT=3'b000 always.
REQ-029 wr_count/rd_count increment by 1 on B/R handshake; wrap 16'hFFFF->0.
REQ-030 err_count increments when captured response != 2'b00; saturates at 8'hFF.
REQ-031 Unused states decode to IDLE.

Reset
REQ-032 ARESETn=0 at ACLK edge: state=IDLE; all VALID/READY outputs, rsp_valid=0; cmd_ready=0 during reset, 1 first cycle after; rsp_rdata, rsp_resp, rsp_write, AWADDR, ARADDR, WDATA=0; WSTRB=0; all counters=0.
REQ-033 Reset mid-transaction abandons it immediately; no response issued; counters cleared.

Verification
REQ-034 Write 0x0000_0000 <- 0x1234_5678, strb 4'hF, slave AWREADY/WREADY same cycle, BRESP=00 -> WDATA=0x12345678, rsp_valid with rsp_resp=00, rsp_write=1, wr_count=1.
REQ-035 Write with AWREADY 3 cycles before WREADY (WREADY delayed 5) -> AWVALID drops after AW handshake, WVALID held until cycle 5, single B accepted.
REQ-036 Read with slave returning RDATA=0xDEAD_BEEF, RRESP=00 after 4-cycle ARREADY stall -> ARVALID held 4 cycles, rsp_rdata=0xDEADBEEF, rd_count=1.
REQ-037 Read returning RRESP=2'b10 -> rsp_resp=10, err_count=1; 300 such reads -> err_count=8'hFF.
REQ-038 rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0, no new AXI activity.
REQ-039 ARESETn=0 while AWVALID=1 awaiting AWREADY -> next cycle AWVALID=0, state IDLE, counters 0, no rsp_valid.

Source files
------------

// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------------------------
// axi_lite_master
//
// Turns single user commands into AXI4-Lite read or write transactions, one at a time, and
// hands the completed response back on a valid/ready response port. Also keeps running counts
// of completed writes, completed reads and non-OKAY responses.
//
// Ports
//   ACLK, ARESETn        clock; synchronous active-low reset
//   cmd_*                user command port (valid/ready); write selects AW/W/B or AR/R
//   rsp_*                user response port (valid/ready); read data is zero for writes
//   AW*/W*/B*            AXI4-Lite write address, write data and write response channels
//   AR*/R*               AXI4-Lite read address and read data channels
//   wr_count, rd_count   completed write/read transactions, wrapping
//   err_count            responses other than OKAY, saturating
// ---------------------------------------------------------------------------------------------
module axi_lite_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,

  // User command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,

  // User response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_write,

  // AXI4-Lite write address channel
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [2:0]          AWPROT,

  // AXI4-Lite write data channel
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,

  // AXI4-Lite write response channel
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,

  // AXI4-Lite read address channel
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [2:0]          ARPROT,

  // AXI4-Lite read data channel
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,

  // Statistics
  output logic [15:0]         wr_count,
  output logic [15:0]         rd_count,
  output logic [7:0]          err_count
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWreq  = 3'd1,
    StWresp = 3'd2,
    StRreq  = 3'd3,
    StRdata = 3'd4,
    StRsp   = 3'd5
  } state_e;

  state_e              state_q, state_d;

  // Latched command; the AXI side is driven only from these.
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;

  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_write_q, rsp_write_d;

  logic [15:0]         wr_count_q, wr_count_d;
  logic [15:0]         rd_count_q, rd_count_d;
  logic [7:0]          err_count_q, err_count_d;

  logic                aw_hs, w_hs, ar_hs;
  logic                resp_cap;
  logic [1:0]          resp_val;

  assign aw_hs = awvalid_q & AWREADY;
  assign w_hs  = wvalid_q & WREADY;
  assign ar_hs = arvalid_q & ARREADY;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    resp_cap    = 1'b0;
    resp_val    = 2'b00;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          awvalid_d = cmd_write;
          wvalid_d  = cmd_write;
          arvalid_d = ~cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWreq : StRreq;
        end
      end

      StWreq: begin
        // AW and W complete independently; both may land in the same cycle.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = StWresp;
        end
      end

      StWresp: begin
        if (BVALID) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = BRESP;
          rsp_write_d = 1'b1;
          wr_count_d  = wr_count_q + 16'd1;
          resp_cap    = 1'b1;
          resp_val    = BRESP;
          state_d     = StRsp;
        end
      end

      StRreq: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = StRdata;
        end
      end

      StRdata: begin
        if (RVALID) begin
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rsp_write_d = 1'b0;
          rd_count_d  = rd_count_q + 16'd1;
          resp_cap    = 1'b1;
          resp_val    = RRESP;
          state_d     = StRsp;
        end
      end

      StRsp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        // Unreachable encodings fall back to idle with the channels quiet.
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  // Error counter sticks at all-ones instead of wrapping.
  always_comb begin
    err_count_d = err_count_q;
    if (resp_cap && (resp_val != 2'b00) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_write_q <= 1'b0;
      wr_count_q  <= 16'd0;
      rd_count_q  <= 16'd0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  end

  // Held low while reset is asserted so no command is taken during the reset cycle.
  assign cmd_ready = (state_q == StIdle) & ARESETn;

  assign rsp_valid = (state_q == StRsp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = rsp_write_q;

  assign AWADDR  = addr_q;
  assign AWVALID = awvalid_q;
  assign AWPROT  = 3'b000;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = (state_q == StWresp);

  assign ARADDR  = addr_q;
  assign ARVALID = arvalid_q;
  assign ARPROT  = 3'b000;
  assign RREADY  = (state_q == StRdata);

  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// ---------------------------------------------------------------------------------------------
// tb_axi_lite_master
//
// Drives user commands into axi_lite_master against a small AXI4-Lite slave model with
// programmable ready delays and responses. Expected responses are queued when a command is
// issued and compared when the DUT presents the response. A passive monitor counts VALID cycles
// and handshakes and flags VALID drops or payload changes before a handshake.
// ---------------------------------------------------------------------------------------------
module tb_axi_lite_master;

  logic        ACLK;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [15:0] wr_count, rd_count;
  logic [7:0]  err_count;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .rsp_write (rsp_write),
    .AWADDR    (AWADDR),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .AWPROT    (AWPROT),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .BRESP     (BRESP),
    .ARADDR    (ARADDR),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .ARPROT    (ARPROT),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .err_count (err_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_passed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  logic [31:0] r_data = '0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_seen, w_seen, ar_seen;

  // Slave reacts on the falling edge so the DUT sees stable inputs at the rising edge.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0; BVALID = 1'b0; RVALID = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0;
    end else begin
      if (AWREADY) begin
        AWREADY = 1'b0; aw_cnt = 0; aw_seen = 1'b1;
      end else if (AWVALID) begin
        if (aw_cnt >= aw_delay) AWREADY = 1'b1;
        else aw_cnt++;
      end
      if (WREADY) begin
        WREADY = 1'b0; w_cnt = 0; w_seen = 1'b1;
      end else if (WVALID) begin
        if (w_cnt >= w_delay) WREADY = 1'b1;
        else w_cnt++;
      end
      if (BVALID) begin
        BVALID = 1'b0;
      end else if (aw_seen && w_seen) begin
        BVALID = 1'b1; BRESP = b_resp; aw_seen = 1'b0; w_seen = 1'b0;
      end
      if (ARREADY) begin
        ARREADY = 1'b0; ar_cnt = 0; ar_seen = 1'b1;
      end else if (ARVALID) begin
        if (ar_cnt >= ar_delay) ARREADY = 1'b1;
        else ar_cnt++;
      end
      if (RVALID) begin
        RVALID = 1'b0;
      end else if (ar_seen) begin
        RVALID = 1'b1; RDATA = r_data; RRESP = r_resp; ar_seen = 1'b0;
      end
    end
  end

  // ---------------- passive monitor ----------------
  int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_hs = 0, r_hs = 0, viol = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  always @(posedge ACLK) begin
    if (!ARESETn) begin
      p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
    end else begin
      if (AWVALID) aw_cyc <= aw_cyc + 1;
      if (WVALID)  w_cyc  <= w_cyc + 1;
      if (ARVALID) ar_cyc <= ar_cyc + 1;
      if (AWVALID && AWREADY) cap_awaddr <= AWADDR;
      if (WVALID && WREADY) begin cap_wdata <= WDATA; cap_wstrb <= WSTRB; end
      if (ARVALID && ARREADY) cap_araddr <= ARADDR;
      if (BVALID && BREADY) b_hs <= b_hs + 1;
      if (RVALID && RREADY) r_hs <= r_hs + 1;
      if (p_awv && !p_awr && (!AWVALID || AWADDR != p_awaddr)) viol <= viol + 1;
      if (p_wv && !p_wr && (!WVALID || WDATA != p_wdata)) viol <= viol + 1;
      if (p_arv && !p_arr && (!ARVALID || ARADDR != p_araddr)) viol <= viol + 1;
      if ((BREADY && (AWVALID || WVALID || ARVALID || RREADY)) ||
          (RREADY && (AWVALID || WVALID || ARVALID))) viol <= viol + 1;
      if (AWPROT != 3'b000 || ARPROT != 3'b000) viol <= viol + 1;
      p_awv <= AWVALID; p_awr <= AWREADY; p_awaddr <= AWADDR;
      p_wv  <= WVALID;  p_wr  <= WREADY;  p_wdata  <= WDATA;
      p_arv <= ARVALID; p_arr <= ARREADY; p_araddr <= ARADDR;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_wr = '0, exp_rd = '0;
  logic [7:0]  exp_err = '0;

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [1:0] resp, input logic push);
    exp_t e;
    int   n = 0;
    @(negedge ACLK);
    while (!cmd_ready && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) check_eq("cmd_ready_timeout", 64'(0), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    if (push) begin
      e.write = wr;
      e.rdata = wr ? 32'h0 : r_data;
      e.resp  = resp;
      sb.push_back(e);
    end
    @(negedge ACLK);
    // Scramble the command inputs; the transaction in flight must not notice.
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_wstrb = ~strb;
  endtask

  task automatic collect(input int hold);
    exp_t        e;
    int          n = 0, unstable = 0, busy = 0, crdy = 0;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic        s_write;
    while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) begin
      check_eq("rsp_valid_timeout", 64'(0), 64'(1));
      return;
    end
    if (hold > 0) begin
      s_rdata = rsp_rdata; s_resp = rsp_resp; s_write = rsp_write;
      for (int i = 0; i < hold; i++) begin
        @(negedge ACLK);
        if (!rsp_valid || rsp_rdata != s_rdata || rsp_resp != s_resp || rsp_write != s_write)
          unstable++;
        if (AWVALID || WVALID || ARVALID || BREADY || RREADY) busy++;
        if (cmd_ready) crdy++;
      end
      check_eq("hold_rsp_stable", 64'(unstable), 64'(0));
      check_eq("hold_axi_idle", 64'(busy), 64'(0));
      check_eq("hold_cmd_ready", 64'(crdy), 64'(0));
    end
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'(0), 64'(1));
      return;
    end
    e = sb.pop_front();
    if (e.write) exp_wr = exp_wr + 16'd1;
    else exp_rd = exp_rd + 16'd1;
    if (e.resp != 2'b00 && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    check_eq("rsp_write", 64'(rsp_write), 64'(e.write));
    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
    check_eq("rsp_resp", 64'(rsp_resp), 64'(e.resp));
    check_eq("wr_count", 64'(wr_count), 64'(exp_wr));
    check_eq("rd_count", 64'(rd_count), 64'(exp_rd));
    check_eq("err_count", 64'(err_count), 64'(exp_err));
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", 64'(rsp_valid), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  int          aw0, w0, ar0, b0, q;
  logic [31:0] a, d;
  logic        wr;
  logic [1:0]  rr;

  initial begin
    ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check_eq("rst_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}), 64'(0));
    check_eq("rst_payload", 64'({AWADDR, WDATA}), 64'(0));
    check_eq("rst_rsp", 64'({rsp_rdata, rsp_resp, rsp_write, WSTRB, ARADDR}), 64'(0));
    check_eq("rst_counts", 64'({wr_count, rd_count, err_count}), 64'(0));
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check_eq("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

    // Basic write, AW and W ready in the same cycle.
    aw_delay = 0; w_delay = 0; b_resp = 2'b00;
    b0 = b_hs;
    issue(1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 2'b00, 1'b1);
    collect(0);
    check_eq("wr1_wdata", 64'(cap_wdata), 64'(32'h1234_5678));
    check_eq("wr1_awaddr", 64'(cap_awaddr), 64'(0));
    check_eq("wr1_wstrb", 64'(cap_wstrb), 64'(4'hF));
    check_eq("wr1_b_hs", 64'(b_hs - b0), 64'(1));

    // AW accepted three cycles before W: AWVALID sees 3 rising edges, WVALID sees 6.
    aw_delay = 2; w_delay = 5;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs;
    issue(1'b1, 32'h0000_0040, 32'hA5A5_0F0F, 4'h5, 2'b00, 1'b1);
    collect(0);
    check_eq("wr2_aw_cycles", 64'(aw_cyc - aw0), 64'(3));
    check_eq("wr2_w_cycles", 64'(w_cyc - w0), 64'(6));
    check_eq("wr2_b_hs", 64'(b_hs - b0), 64'(1));
    check_eq("wr2_awaddr", 64'(cap_awaddr), 64'(32'h40));
    check_eq("wr2_wdata", 64'(cap_wdata), 64'(32'hA5A5_0F0F));
    check_eq("wr2_wstrb", 64'(cap_wstrb), 64'(4'h5));

    // Read with 4 stall cycles on ARREADY before the handshake cycle.
    ar_delay = 4; r_data = 32'hDEAD_BEEF; r_resp = 2'b00;
    ar0 = ar_cyc;
    issue(1'b0, 32'h0000_1000, 32'h0, 4'h0, 2'b00, 1'b1);
    collect(0);
    check_eq("rd1_ar_cycles", 64'(ar_cyc - ar0), 64'(5));
    check_eq("rd1_araddr", 64'(cap_araddr), 64'(32'h1000));

    // SLVERR reads: error counter climbs and then saturates.
    ar_delay = 0; r_resp = 2'b10;
    for (int i = 0; i < 300; i++) begin
      r_data = $urandom;
      issue(1'b0, $urandom, 32'h0, 4'h0, 2'b10, 1'b1);
      collect(0);
    end
    check_eq("err_saturated", 64'(err_count), 64'(8'hFF));
    check_eq("rd_count_300", 64'(rd_count), 64'(16'd301));

    // Response back-pressure on a write and a read.
    b_resp = 2'b01; aw_delay = 1; w_delay = 0;
    issue(1'b1, 32'h0000_2000, 32'h0BAD_F00D, 4'h3, 2'b01, 1'b1);
    collect(10);
    r_resp = 2'b00; r_data = 32'hCAFE_0001; ar_delay = 2;
    issue(1'b0, 32'h0000_2004, 32'h0, 4'h0, 2'b00, 1'b1);
    collect(10);

    // Mixed traffic with random delays and responses.
    for (int i = 0; i < 12; i++) begin
      wr = 1'($urandom_range(0, 1));
      rr = 2'($urandom_range(0, 3));
      a = $urandom; d = $urandom;
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3);
      b_resp = rr; r_resp = rr; r_data = $urandom;
      issue(wr, a, d, 4'($urandom_range(0, 15)), rr, 1'b1);
      collect(0);
      if (wr) check_eq("mix_wdata", 64'(cap_wdata), 64'(d));
      else check_eq("mix_araddr", 64'(cap_araddr), 64'(a));
    end

    // Reset while AWVALID waits for a slow AWREADY: transaction abandoned.
    aw_delay = 50; w_delay = 0;
    issue(1'b1, 32'h0000_3000, 32'h1111_2222, 4'hF, 2'b00, 1'b0);
    repeat (3) @(negedge ACLK);
    check_eq("pre_rst_awvalid", 64'(AWVALID), 64'(1));
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    check_eq("mid_rst_awvalid", 64'(AWVALID), 64'(0));
    check_eq("mid_rst_valids", 64'({WVALID, ARVALID, BREADY, RREADY, rsp_valid}), 64'(0));
    check_eq("mid_rst_counts", 64'({wr_count, rd_count, err_count}), 64'(0));
    check_eq("mid_rst_payload", 64'({AWADDR, WDATA}), 64'(0));
    check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge ACLK);
    ARESETn = 1'b1;
    exp_wr = '0; exp_rd = '0; exp_err = '0;
    #1;
    check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    q = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      if (rsp_valid || AWVALID || WVALID) q++;
    end
    check_eq("post_rst_quiet", 64'(q), 64'(0));

    // A clean read after the abandoned write.
    aw_delay = 0; ar_delay = 1; r_resp = 2'b00; r_data = 32'h7654_3210;
    issue(1'b0, 32'h0000_4000, 32'h0, 4'h0, 2'b00, 1'b1);
    collect(0);

    check_eq("protocol_violations", 64'(viol), 64'(0));
    check_eq("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
